// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//   Shares one iterative AES-128 core between NUM_REQ requesters. It accepts
//   one request at a time, chosen round-robin, and drives the core. When the
//   core finishes, or times out, it returns the result tagged with the
//   requester ID.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot or zero)
//   req_data/req_key        packed 128-bit plaintext/key per requester
//   core_start              one-cycle start pulse to the core
//   core_data/core_key      latched plaintext/key, stable until response exits
//   core_done/core_result   completion pulse and ciphertext from the core
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_data/rsp_err requester index, ciphertext (0 on error), timeout flag
//   busy                    high in every state except IDLE
module aes_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [128*NUM_REQ-1:0]   req_data,
  input  logic [128*NUM_REQ-1:0]   req_key,
  output logic                     core_start,
  output logic [127:0]             core_data,
  output logic [127:0]             core_key,
  input  logic                     core_done,
  input  logic [127:0]             core_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [127:0]             rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_e;

  localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ID_W:0]   NREQ_W   = (ID_W+1)'(NUM_REQ);

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]          timer_q;
  logic                core_start_q, rsp_valid_q, rsp_err_q, busy_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [127:0]        core_data_q, core_key_q, rsp_data_q;

  // Round-robin search: rotate the request vector so that rr_ptr sits at bit 0.
  // The lowest set bit then gives the offset from rr_ptr.
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      off, gnt_idx;
  logic [ID_W:0]        sum;
  logic                 grant_en;
  logic [127:0]         sel_data, sel_key;

  assign dbl = {req_valid, req_valid};
  assign rot = NUM_REQ'(dbl >> rr_ptr_q);

  always_comb begin
    off = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (rot[k]) off = ID_W'(k);
  end

  assign sum     = {1'b0, rr_ptr_q} + {1'b0, off};
  assign gnt_idx = (sum >= NREQ_W) ? ID_W'(sum - NREQ_W) : ID_W'(sum);

  // While reset is held, req_ready is suppressed even though the state reads IDLE.
  assign grant_en = reset && (state_q == S_IDLE) && (|req_valid);

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = grant_en && (gnt_idx == ID_W'(k));
      if (gnt_idx == ID_W'(k)) begin
        sel_data = req_data[128*k +: 128];
        sel_key  = req_key[128*k +: 128];
      end
    end
  end

  // The pointer restarts just past the requester that was served last.
  always_comb begin
    rr_ptr_d = rsp_id_q + 1'b1;
    if ({1'b0, rsp_id_q} + 1'b1 >= NREQ_W) rr_ptr_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      timer_q      <= '0;
      core_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      core_data_q  <= '0;
      core_key_q   <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_en) begin
            core_data_q  <= sel_data;
            core_key_q   <= sel_key;
            rsp_id_q     <= gnt_idx;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a timeout in the same cycle
          if (core_done) begin
            rsp_data_q  <= core_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (timer_q == TMO_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_data  = core_data_q;
  assign core_key   = core_key_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter. A stub AES core sits behind the arbiter. Each
// transaction is predicted from the round-robin rule and the timeout rule.
module tb_aes_core_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid, req_ready;
  logic [128*N-1:0]   req_data, req_key;
  logic               core_start, core_done, rsp_valid, rsp_ready, rsp_err, busy;
  logic [127:0]       core_data, core_key, core_result, rsp_data;
  logic [IW-1:0]      rsp_id;

  aes_core_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .core_start(core_start), .core_data(core_data), .core_key(core_key),
    .core_done(core_done), .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rr    = 0;     // model round-robin pointer
  int core_lat = 0;  // cycles from core_start to done; 0 = never answers
  bit force_done = 1'b0;

  // Stand-in for the AES core. It returns the FIPS-197 ciphertext for the known vector, otherwise a keyed scramble.
  function automatic logic [127:0] aes_stub(input logic [127:0] d, input logic [127:0] k);
    if (d == PT1 && k == K1) return CT1;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  // Stub core, updated mid-cycle so its outputs are settled before the next rising edge.
  int          cnt = 0;
  bit          pending = 1'b0;
  logic [127:0] lat_d = '0, lat_k = '0;
  always @(negedge clk) begin
    bit d;
    d = 1'b0;
    if (!reset) pending = 1'b0;
    else begin
      if (pending) begin
        cnt--;
        if (cnt == 0) begin d = 1'b1; pending = 1'b0; end
      end
      if (core_start === 1'b1 && core_lat > 0) begin
        pending = 1'b1; cnt = core_lat; lat_d = core_data; lat_k = core_key;
      end
    end
    core_done   = d | force_done;
    core_result = d ? aes_stub(lat_d, lat_k) : 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
  end

  function automatic int grant_of(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_lanes;
    for (int i = 0; i < N; i++) begin
      req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      req_key[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Runs one transaction from the IDLE cycle through the response handshake.
  task automatic txn(input logic [N-1:0] mask, input int lat, input int hold, input bit keep,
                     output int gid, output logic [127:0] got);
    int g, k, starts;
    bit seen, ok;
    logic [127:0] ed, ek, er;
    g  = grant_of(mask, rr);
    ed = req_data[128*g +: 128];
    ek = req_key[128*g +: 128];
    ok = (lat >= 1 && lat <= TO);
    er = ok ? aes_stub(ed, ek) : 128'h0;
    core_lat  = lat;
    rsp_ready = 1'b0;
    req_valid = mask;
    #1;
    chk("req_ready_grant", 128'(req_ready), 128'(1) << g);
    chk("busy_idle", 128'(busy), 128'd0);
    tick;
    if (!keep) req_valid = '0;
    chk("core_start", 128'(core_start), 128'd1);
    chk("core_data", core_data, ed);
    chk("core_key", core_key, ek);
    chk("busy_start", 128'(busy), 128'd1);
    chk("req_ready_start", 128'(req_ready), 128'd0);
    k = 0; seen = 1'b0; starts = 0;
    while (!seen && k < 40) begin
      tick; k++;
      if (core_start === 1'b1) starts++;
      if (rsp_valid === 1'b1) seen = 1'b1;
      else if (req_ready !== '0) chk("req_ready_wait", 128'(req_ready), 128'd0);
    end
    chk("start_once", 128'(starts), 128'd0);
    chk("rsp_latency", 128'(k), ok ? 128'(lat + 1) : 128'(TO + 1));
    chk("rsp_id", 128'(rsp_id), 128'(g));
    chk("rsp_data", rsp_data, er);
    chk("rsp_err", 128'(rsp_err), ok ? 128'd0 : 128'd1);
    gid = int'(rsp_id);
    got = rsp_data;
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold_valid", 128'(rsp_valid), 128'd1);
      chk("hold_data", rsp_data, er);
      chk("hold_id", 128'(rsp_id), 128'(g));
      chk("hold_err", 128'(rsp_err), ok ? 128'd0 : 128'd1);
      chk("hold_ready", 128'(req_ready), 128'd0);
      chk("hold_busy", 128'(busy), 128'd1);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_drop", 128'(rsp_valid), 128'd0);
    chk("busy_back", 128'(busy), 128'd0);
    rr = (g + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid;
    logic [127:0] got;
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_data = '0; req_key = '0;
    rand_lanes;
    req_valid = 4'b1111;
    tick; tick;
    // reset state
    chk("rst_ready", 128'(req_ready), 128'd0);
    chk("rst_start", 128'(core_start), 128'd0);
    chk("rst_valid", 128'(rsp_valid), 128'd0);
    chk("rst_err", 128'(rsp_err), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_id", 128'(rsp_id), 128'd0);
    chk("rst_rdata", rsp_data, 128'd0);
    chk("rst_cdata", core_data, 128'd0);
    chk("rst_ckey", core_key, 128'd0);
    req_valid = '0;
    reset = 1'b1;
    tick;

    // fairness, all requesting, back-to-back
    for (int i = 0; i < 6; i++) begin
      txn(4'b1111, 3, 0, 1'b1, gid, got);
      chk("rr_order", 128'(gid), 128'(exp_order[i]));
    end
    req_valid = '0;
    tick;

    // FIPS-197 vector on requester 2
    rand_lanes;
    req_data[256 +: 128] = PT1;
    req_key[256 +: 128]  = K1;
    txn(4'b0100, 11, 0, 1'b0, gid, got);
    chk("fips_id", 128'(gid), 128'd2);
    chk("fips_ct", got, CT1);

    // timeout, then a stray late done
    rand_lanes;
    txn(4'b0010, 0, 0, 1'b0, gid, got);
    force_done = 1'b1;
    tick;
    force_done = 1'b0;
    tick;
    chk("late_done_valid", 128'(rsp_valid), 128'd0);
    chk("late_done_busy", 128'(busy), 128'd0);

    // done in the timeout cycle
    rand_lanes;
    txn(4'b1000, TO, 0, 1'b0, gid, got);

    // backpressure while others keep requesting
    rand_lanes;
    txn(4'b1011, 5, 5, 1'b1, gid, got);
    req_valid = '0;
    tick;

    // reset in the middle of WAIT
    core_lat  = 0;
    req_valid = 4'b1000;
    tick; tick; tick;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(req_ready), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rst_cdata", core_data, 128'd0);
    chk("mid_rst_rdata", rsp_data, 128'd0);
    chk("mid_rst_id", 128'(rsp_id), 128'd0);
    req_valid  = '0;
    force_done = 1'b1;
    tick; tick;
    force_done = 1'b0;
    reset = 1'b1;
    rr = 0;
    tick; tick;
    chk("post_rst_valid", 128'(rsp_valid), 128'd0);
    chk("post_rst_busy", 128'(busy), 128'd0);
    rand_lanes;
    txn(4'b1111, 2, 0, 1'b0, gid, got);
    chk("post_rst_grant", 128'(gid), 128'd0);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      rand_lanes;
      txn(N'($urandom_range(1, 15)), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), gid, got);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = '0;
        tick;
      end
    end
    req_valid = '0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
